slow_clk_monitor: RTL and testbench
===================================

// Module: slow_clk_monitor
// PURPOSE
//  Fast-domain consumer of the divided AON slow clock (32.768 kHz class).
//  - Synchronises slow_clk into clk.
//  - Emits one-cycle rise/fall strobes.
//  - Measures the slow-clock period in clk cycles.
//  - Flags frequency error or loss of the slow clock so SoC logic can react.
// PARAMETERS
//  SYNC_STAGES  2     synchroniser flops on slow_clk (>=2)
//  CNT_W        16    period counter / period_o width
//  EXP_PERIOD   10    expected period in clk cycles (2*DIVIDER of the divider)
//  TOL          1     allowed |period-EXP_PERIOD| before freq_err_o
//  TIMEOUT      64    clk cycles without a rise => clock lost (<=2^CNT_W-1)
// PORTS
//  clk            in   1      fast system clock; only clock in block
//  reset          in   1      synchronous, active-high reset
//  enable_i       in   1      monitor enable
//  slow_clk_i     in   1      divided clock, asynchronous to clk
//  rise_o         out  1      1-cycle pulse per synchronised rising edge
//  fall_o         out  1      1-cycle pulse per synchronised falling edge
//  period_o       out  CNT_W  last measured rise-to-rise period (clk cycles)
//  period_vld_o   out  1      1-cycle pulse when period_o updates
//  freq_err_o     out  1      last period outside EXP_PERIOD+/-TOL
//  clk_lost_o     out  1      sticky: no rise seen for TIMEOUT cycles
// BEHAVIOUR
//  Reset: sync chain, edge register, counter, state <= 0/IDLE.
//    All outputs 0, including period_o.
//  Reset applied mid-measurement aborts it; no partial period is reported.
//  Sync and edge detect:
//    - s = last sync flop; s_d = s delayed one cycle.
//    - rise = s & ~s_d; fall = ~s & s_d.
//    - rise_o/fall_o are registered.
//    - Latency: SYNC_STAGES+1 clk cycles from input edge to strobe.
//  States:
//    - IDLE: enable_i=0. cnt=0; rise/fall/period_vld suppressed.
//      clk_lost_o=0. period_o and freq_err_o hold.
//      enable_i=1 -> ACQ.
//    - ACQ: wait first rise. cnt increments each cycle.
//      On rise: cnt<=1 -> MEAS (no period reported).
//      cnt==TIMEOUT without rise: clk_lost_o<=1, cnt<=0, stay ACQ.
//    - MEAS: cnt increments each cycle.
//      On rise: period_o<=cnt, period_vld_o<=1, cnt<=1.
//        freq_err_o <= |cnt-EXP_PERIOD|>TOL, in the same cycle.
//      cnt==TIMEOUT without rise: clk_lost_o<=1 -> ACQ, cnt<=0.
//    - enable_i=0 in any state -> IDLE on the next cycle.
//  clk_lost_o clears on the next rise, or on reset/disable.
//    That rise is treated as a first edge (ACQ->MEAS); no period.
//  Rise in the same cycle as cnt==TIMEOUT: the rise wins; no loss flagged.
//  cnt saturates at 2^CNT_W-1 and never wraps.
//  Compare arithmetic uses CNT_W+1 bits, signed-safe.
//  Glitch-free input is assumed by the protocol.
//    Pulses shorter than 1 clk may be missed; this is not an error.
// TESTING
//  1 slow_clk toggles every 5 clk, enabled. Response:
//    First rise gives no period_vld.
//    Thereafter period_o=10, period_vld_o every 10 clk.
//    freq_err_o=0, clk_lost_o=0.
//  2 Toggle every 7 clk. Response: period_o=14, freq_err_o=1.
//    Back to 5 -> the next measurement has freq_err_o=0.
//  3 Stop slow_clk after steady run. Response:
//    clk_lost_o=1 exactly 64 clk after the last rise_o.
//    Restart: first rise clears it; period_vld on the 2nd rise.
//  4 Input edge at cycle t. Response: rise_o high only at t+3
//    (SYNC_STAGES=2); fall_o likewise for falling edges.
//  5 Reset pulsed mid-period. Response: all outputs 0 next cycle.
//    First period_vld after 2 more rises.
//  6 enable_i=0 while measuring. Response:
//    - No strobes; period_o holds 10; clk_lost_o=0 even with slow_clk stopped.
//    - After re-enable, no period_vld until two rises.

Source files
------------

// File: rtl/slow_clk_monitor_if.sv
// Bundle between the slow-clock monitor and its SoC-side user.
// The slave side is the monitor itself: it consumes the enable and the
// divided slow clock and produces the strobes, period and status flags.
// The master side drives the enable and slow clock and observes the status.
interface slow_clk_monitor_if #(
    parameter int CNT_W = 16
);
    logic             enable_i;
    logic             slow_clk_i;
    logic             rise_o;
    logic             fall_o;
    logic [CNT_W-1:0] period_o;
    logic             period_vld_o;
    logic             freq_err_o;
    logic             clk_lost_o;

    modport master (
        output enable_i,
        output slow_clk_i,
        input  rise_o,
        input  fall_o,
        input  period_o,
        input  period_vld_o,
        input  freq_err_o,
        input  clk_lost_o
    );

    modport slave (
        input  enable_i,
        input  slow_clk_i,
        output rise_o,
        output fall_o,
        output period_o,
        output period_vld_o,
        output freq_err_o,
        output clk_lost_o
    );
endinterface

// File: rtl/slow_clk_monitor.sv
// Fast-domain monitor for the divided always-on slow clock.
// The slow clock is synchronised into clk, turned into one-cycle rise/fall
// strobes, and its rise-to-rise period is measured in clk cycles. A period
// outside EXP_PERIOD +/- TOL raises freq_err_o; TIMEOUT cycles without a
// rise raise the sticky clk_lost_o until the next rise, disable or reset.
module slow_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int EXP_PERIOD  = 10,
    parameter int TOL         = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset,
    slow_clk_monitor_if.slave mon
);

    // Controller states: disabled, waiting for a reference rise, measuring.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Deviation arithmetic is one bit wider and signed so that periods
    // shorter than EXP_PERIOD produce a proper negative difference.
    localparam logic signed [CNT_W:0] EXP_C     = (CNT_W+1)'(EXP_PERIOD);
    localparam logic signed [CNT_W:0] TOL_C     = (CNT_W+1)'(TOL);
    localparam logic signed [CNT_W:0] DIFF_ZERO = {(CNT_W+1){1'b0}};

    // Synchroniser and edge-detect state.
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    logic                   sync_s;
    logic                   rise_s;
    logic                   fall_s;

    // Controller and measurement state.
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             timeout_s;

    // Registered outputs.
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] period_r;
    logic             period_vld_r;
    logic             freq_err_r;
    logic             clk_lost_r;

    // Period deviation check.
    logic signed [CNT_W:0] diff_s;
    logic signed [CNT_W:0] abs_s;
    logic                  dev_err_s;

    // Next-state values.
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             rise_nxt_s;
    logic             fall_nxt_s;
    logic [CNT_W-1:0] period_nxt_s;
    logic             period_vld_nxt_s;
    logic             freq_err_nxt_s;
    logic             clk_lost_nxt_s;

    // Edge detection on the synchronised level against its one-cycle delay.
    always_comb begin
        sync_s = sync_r[SYNC_STAGES-1];
        rise_s = sync_s & ~s_d_r;
        fall_s = ~sync_s & s_d_r;
    end

    // Counter helpers: saturating increment and timeout detection.
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = CNT_MAX;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
        timeout_s = (cnt_r == TIMEOUT_C);
    end

    // |cnt - EXP_PERIOD| > TOL, evaluated on the period about to be reported.
    always_comb begin
        diff_s = $signed({1'b0, cnt_r}) - EXP_C;
        if (diff_s < DIFF_ZERO) begin
            abs_s = -diff_s;
        end else begin
            abs_s = diff_s;
        end
        dev_err_s = (abs_s > TOL_C);
    end

    // Controller: decides counter, strobes, period report and loss flag.
    // A rise takes priority over a coincident timeout.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        rise_nxt_s       = 1'b0;
        fall_nxt_s       = 1'b0;
        period_nxt_s     = period_r;
        period_vld_nxt_s = 1'b0;
        freq_err_nxt_s   = freq_err_r;
        clk_lost_nxt_s   = clk_lost_r;

        if (!mon.enable_i) begin
            // Disable wins from any state; period and freq_err hold.
            state_nxt_s    = ST_IDLE;
            cnt_nxt_s      = CNT_ZERO;
            clk_lost_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Leaving IDLE: edges in this cycle are not yet observed.
                    state_nxt_s = ST_ACQ;
                    cnt_nxt_s   = CNT_ZERO;
                end
                ST_ACQ: begin
                    rise_nxt_s = rise_s;
                    fall_nxt_s = fall_s;
                    if (rise_s) begin
                        // First edge becomes the reference; nothing to report.
                        state_nxt_s    = ST_MEAS;
                        cnt_nxt_s      = CNT_ONE;
                        clk_lost_nxt_s = 1'b0;
                    end else if (timeout_s) begin
                        clk_lost_nxt_s = 1'b1;
                        cnt_nxt_s      = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                ST_MEAS: begin
                    rise_nxt_s = rise_s;
                    fall_nxt_s = fall_s;
                    if (rise_s) begin
                        period_nxt_s     = cnt_r;
                        period_vld_nxt_s = 1'b1;
                        freq_err_nxt_s   = dev_err_s;
                        cnt_nxt_s        = CNT_ONE;
                        clk_lost_nxt_s   = 1'b0;
                    end else if (timeout_s) begin
                        // Lost clock: fall back to acquiring a new reference.
                        clk_lost_nxt_s = 1'b1;
                        state_nxt_s    = ST_ACQ;
                        cnt_nxt_s      = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Synchroniser chain and edge register; runs while disabled so that
    // re-enabling never sees a stale level as a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], mon.slow_clk_i};
            s_d_r  <= sync_s;
        end
    end

    // Controller state, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            rise_r       <= 1'b0;
            fall_r       <= 1'b0;
            period_r     <= CNT_ZERO;
            period_vld_r <= 1'b0;
            freq_err_r   <= 1'b0;
            clk_lost_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            rise_r       <= rise_nxt_s;
            fall_r       <= fall_nxt_s;
            period_r     <= period_nxt_s;
            period_vld_r <= period_vld_nxt_s;
            freq_err_r   <= freq_err_nxt_s;
            clk_lost_r   <= clk_lost_nxt_s;
        end
    end

    assign mon.rise_o       = rise_r;
    assign mon.fall_o       = fall_r;
    assign mon.period_o     = period_r;
    assign mon.period_vld_o = period_vld_r;
    assign mon.freq_err_o   = freq_err_r;
    assign mon.clk_lost_o   = clk_lost_r;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Self-checking bench for slow_clk_monitor. A timestamp-based reference
// model (input sample history, last-rise time, mode) predicts every output;
// scenario tasks also check the fixed values of the nominal configuration.
module tb_slow_clk_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;
    localparam int EXP_PERIOD  = 10;
    localparam int TOL         = 1;
    localparam int TIMEOUT     = 64;

    localparam int MODE_OFF  = 0;
    localparam int MODE_ACQ  = 1;
    localparam int MODE_MEAS = 2;

    logic clk;
    logic reset;

    slow_clk_monitor_if #(.CNT_W(CNT_W)) bus ();

    slow_clk_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .EXP_PERIOD  (EXP_PERIOD),
        .TOL         (TOL),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Slow clock generator controls: half_per>0 toggles every half_per clk,
    // half_per==0 holds the level man_lvl.
    int half_per = 0;
    bit man_lvl  = 1'b0;
    int ph_cnt   = 0;

    // Reference model state.
    bit samp_q[$];
    int edge_n    = 0;
    int m_mode    = MODE_OFF;
    int win_start = 0;
    bit m_rise    = 1'b0;
    bit m_fall    = 1'b0;
    bit m_vld     = 1'b0;
    bit m_err     = 1'b0;
    bit m_lost    = 1'b0;
    int m_period  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slow clock source, changing 1 time unit after the falling edge.
    initial begin
        bus.slow_clk_i = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (half_per == 0) begin
                bus.slow_clk_i = man_lvl;
                ph_cnt = 0;
            end else if (ph_cnt + 1 >= half_per) begin
                bus.slow_clk_i = ~bus.slow_clk_i;
                ph_cnt = 0;
            end else begin
                ph_cnt++;
            end
        end
    end

    // Reference model: at each clk edge, predict what the outputs become.
    // samp_q[j] holds the input sampled j+1 edges ago; a synchronised edge
    // is reported SYNC_STAGES+1 cycles after the input changed.
    task automatic model_step();
        bit rise_ev;
        bit fall_ev;
        int cnt;
        edge_n++;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_vld  = 1'b0;
        if (reset) begin
            samp_q.delete();
            for (int i = 0; i <= SYNC_STAGES; i++) samp_q.push_back(1'b0);
            m_mode   = MODE_OFF;
            m_period = 0;
            m_err    = 1'b0;
            m_lost   = 1'b0;
        end else begin
            rise_ev = samp_q[SYNC_STAGES-1] && !samp_q[SYNC_STAGES];
            fall_ev = !samp_q[SYNC_STAGES-1] && samp_q[SYNC_STAGES];
            samp_q.push_front(bus.slow_clk_i);
            void'(samp_q.pop_back());
            if (!bus.enable_i) begin
                m_mode = MODE_OFF;
                m_lost = 1'b0;
            end else if (m_mode == MODE_OFF) begin
                m_mode    = MODE_ACQ;
                win_start = edge_n + 1;
            end else begin
                cnt    = edge_n - win_start;
                m_rise = rise_ev;
                m_fall = fall_ev;
                if (rise_ev) begin
                    if (m_mode == MODE_MEAS) begin
                        m_vld    = 1'b1;
                        m_period = cnt;
                        m_err    = (cnt > EXP_PERIOD + TOL) || (cnt < EXP_PERIOD - TOL);
                    end
                    m_lost    = 1'b0;
                    m_mode    = MODE_MEAS;
                    win_start = edge_n;
                end else if (cnt == TIMEOUT) begin
                    m_lost    = 1'b1;
                    m_mode    = MODE_ACQ;
                    win_start = edge_n + 1;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic test_reset();
        reset = 1'b1;
        bus.enable_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.rise_o !== 1'b0) begin n_fail++; $display("FAIL reset_rise got=%b exp=0", bus.rise_o); end
        n_checks++;
        if (bus.fall_o !== 1'b0) begin n_fail++; $display("FAIL reset_fall got=%b exp=0", bus.fall_o); end
        n_checks++;
        if (bus.period_o !== 16'd0) begin n_fail++; $display("FAIL reset_period got=%0d exp=0", bus.period_o); end
        n_checks++;
        if (bus.period_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", bus.period_vld_o); end
        n_checks++;
        if (bus.freq_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.freq_err_o); end
        n_checks++;
        if (bus.clk_lost_o !== 1'b0) begin n_fail++; $display("FAIL reset_lost got=%b exp=0", bus.clk_lost_o); end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        int rise_cnt = 0;
        int vld_cnt  = 0;
        int first_vld_rise = 0;
        int last_vld = 0;
        bus.enable_i = 1'b1;
        half_per = 5;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (bus.rise_o === 1'b1) rise_cnt++;
            n_checks++;
            if (bus.rise_o !== m_rise) begin n_fail++; $display("FAIL nom_rise c=%0d got=%b exp=%b", c, bus.rise_o, m_rise); end
            n_checks++;
            if (bus.fall_o !== m_fall) begin n_fail++; $display("FAIL nom_fall c=%0d got=%b exp=%b", c, bus.fall_o, m_fall); end
            n_checks++;
            if (bus.period_vld_o !== m_vld) begin n_fail++; $display("FAIL nom_vld c=%0d got=%b exp=%b", c, bus.period_vld_o, m_vld); end
            n_checks++;
            if (bus.clk_lost_o !== 1'b0) begin n_fail++; $display("FAIL nom_lost c=%0d got=%b exp=0", c, bus.clk_lost_o); end
            if (bus.period_vld_o === 1'b1) begin
                vld_cnt++;
                if (vld_cnt == 1) first_vld_rise = rise_cnt;
                n_checks++;
                if (bus.period_o !== 16'd10) begin n_fail++; $display("FAIL nom_period c=%0d got=%0d exp=10", c, bus.period_o); end
                n_checks++;
                if (bus.freq_err_o !== 1'b0) begin n_fail++; $display("FAIL nom_err c=%0d got=%b exp=0", c, bus.freq_err_o); end
                if (vld_cnt > 1) begin
                    n_checks++;
                    if (c - last_vld != 10) begin n_fail++; $display("FAIL nom_spacing got=%0d exp=10", c - last_vld); end
                end
                last_vld = c;
            end
        end
        n_checks++;
        if (first_vld_rise != 2) begin n_fail++; $display("FAIL nom_first_vld got_rise=%0d exp_rise=2", first_vld_rise); end
        n_checks++;
        if (vld_cnt < 13) begin n_fail++; $display("FAIL nom_vld_count got=%0d exp>=13", vld_cnt); end
    endtask

    task automatic test_freq_change();
        int vld_cnt = 0;
        half_per = 7;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.period_vld_o !== m_vld) begin n_fail++; $display("FAIL slow_vld c=%0d got=%b exp=%b", c, bus.period_vld_o, m_vld); end
            if (bus.period_vld_o === 1'b1) begin
                vld_cnt++;
                n_checks++;
                if (bus.period_o !== CNT_W'(m_period)) begin n_fail++; $display("FAIL slow_model_period got=%0d exp=%0d", bus.period_o, m_period); end
                if (vld_cnt >= 2) begin
                    n_checks++;
                    if (bus.period_o !== 16'd14) begin n_fail++; $display("FAIL slow_period got=%0d exp=14", bus.period_o); end
                    n_checks++;
                    if (bus.freq_err_o !== 1'b1) begin n_fail++; $display("FAIL slow_err got=%b exp=1", bus.freq_err_o); end
                end
            end
        end
        half_per = 5;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.freq_err_o !== m_err) begin n_fail++; $display("FAIL back_err c=%0d got=%b exp=%b", c, bus.freq_err_o, m_err); end
        end
        n_checks++;
        if (bus.period_o !== 16'd10) begin n_fail++; $display("FAIL back_period got=%0d exp=10", bus.period_o); end
        n_checks++;
        if (bus.freq_err_o !== 1'b0) begin n_fail++; $display("FAIL back_err_final got=%b exp=0", bus.freq_err_o); end
    endtask

    task automatic test_loss();
        int cyc = 0;
        int last_rise = 0;
        int lost_at = -1;
        int rises = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cyc++;
            if (bus.rise_o === 1'b1) last_rise = cyc;
        end
        man_lvl = bus.slow_clk_i;
        half_per = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            cyc++;
            if (bus.rise_o === 1'b1) last_rise = cyc;
            n_checks++;
            if (bus.clk_lost_o !== m_lost) begin n_fail++; $display("FAIL loss_model c=%0d got=%b exp=%b", c, bus.clk_lost_o, m_lost); end
            if (bus.clk_lost_o === 1'b1 && lost_at < 0) lost_at = cyc;
        end
        n_checks++;
        if (lost_at < 0) begin
            n_fail++; $display("FAIL loss_never_flagged got=0 exp=1");
        end else if (lost_at - last_rise != TIMEOUT) begin
            n_fail++; $display("FAIL loss_delay got=%0d exp=%0d", lost_at - last_rise, TIMEOUT);
        end
        half_per = 5;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.rise_o === 1'b1) begin
                rises++;
                if (rises == 1) begin
                    n_checks++;
                    if (bus.clk_lost_o !== 1'b0) begin n_fail++; $display("FAIL restart_lost got=%b exp=0", bus.clk_lost_o); end
                    n_checks++;
                    if (bus.period_vld_o !== 1'b0) begin n_fail++; $display("FAIL restart_vld1 got=%b exp=0", bus.period_vld_o); end
                end else if (rises == 2) begin
                    n_checks++;
                    if (bus.period_vld_o !== 1'b1) begin n_fail++; $display("FAIL restart_vld2 got=%b exp=1", bus.period_vld_o); end
                end
            end
        end
        n_checks++;
        if (rises < 2) begin n_fail++; $display("FAIL restart_rises got=%0d exp>=2", rises); end
    endtask

    task automatic test_latency();
        bit lvl;
        man_lvl = bus.slow_clk_i;
        half_per = 0;
        @(negedge clk);
        man_lvl = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            lvl = (i % 2 == 0);
            man_lvl = lvl;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                n_checks++;
                if (lvl) begin
                    if (bus.rise_o !== (k == 3)) begin n_fail++; $display("FAIL lat_rise k=%0d got=%b exp=%b", k, bus.rise_o, (k == 3)); end
                end else begin
                    if (bus.fall_o !== (k == 3)) begin n_fail++; $display("FAIL lat_fall k=%0d got=%b exp=%b", k, bus.fall_o, (k == 3)); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rises = 0;
        int first_vld_rise = 0;
        half_per = 5;
        repeat (33 + $urandom_range(0, 9)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({bus.rise_o, bus.fall_o, bus.period_vld_o, bus.freq_err_o, bus.clk_lost_o} !== 5'b00000)
            begin n_fail++; $display("FAIL rstmid_flags got=%b exp=00000", {bus.rise_o, bus.fall_o, bus.period_vld_o, bus.freq_err_o, bus.clk_lost_o}); end
        n_checks++;
        if (bus.period_o !== 16'd0) begin n_fail++; $display("FAIL rstmid_period got=%0d exp=0", bus.period_o); end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.rise_o === 1'b1) rises++;
            if (bus.period_vld_o === 1'b1 && first_vld_rise == 0) first_vld_rise = rises;
            n_checks++;
            if (bus.period_vld_o !== m_vld) begin n_fail++; $display("FAIL rstmid_vld c=%0d got=%b exp=%b", c, bus.period_vld_o, m_vld); end
        end
        n_checks++;
        if (first_vld_rise != 2) begin n_fail++; $display("FAIL rstmid_first_vld got_rise=%0d exp_rise=2", first_vld_rise); end
    endtask

    task automatic test_disable();
        int rises = 0;
        int first_vld_rise = 0;
        half_per = 5;
        repeat (40) @(negedge clk);
        bus.enable_i = 1'b0;
        for (int c = 0; c < 130; c++) begin
            if (c == 30) begin
                man_lvl = bus.slow_clk_i;
                half_per = 0;
            end
            @(negedge clk);
            n_checks++;
            if ({bus.rise_o, bus.fall_o, bus.period_vld_o} !== 3'b000) begin n_fail++; $display("FAIL dis_strobes c=%0d got=%b exp=000", c, {bus.rise_o, bus.fall_o, bus.period_vld_o}); end
            n_checks++;
            if (bus.clk_lost_o !== 1'b0) begin n_fail++; $display("FAIL dis_lost c=%0d got=%b exp=0", c, bus.clk_lost_o); end
        end
        n_checks++;
        if (bus.period_o !== 16'd10) begin n_fail++; $display("FAIL dis_period_hold got=%0d exp=10", bus.period_o); end
        bus.enable_i = 1'b1;
        half_per = 5;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.rise_o === 1'b1) rises++;
            if (bus.period_vld_o === 1'b1 && first_vld_rise == 0) first_vld_rise = rises;
        end
        n_checks++;
        if (first_vld_rise != 2) begin n_fail++; $display("FAIL reen_first_vld got_rise=%0d exp_rise=2", first_vld_rise); end
    endtask

    task automatic test_random();
        int pick;
        int len;
        bit do_rst;
        for (int blk = 0; blk < 60; blk++) begin
            pick   = $urandom_range(0, 11);
            len    = $urandom_range(20, 90);
            do_rst = ($urandom_range(0, 15) == 0);
            if (pick <= 6) begin
                half_per = 3 + pick;
            end else if (pick <= 9) begin
                half_per = 24 + pick;
            end else if (pick == 10) begin
                man_lvl = bus.slow_clk_i;
                half_per = 0;
            end
            bus.enable_i = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < len; c++) begin
                reset = do_rst && (c == 0);
                @(negedge clk);
                n_checks++;
                if (bus.rise_o !== m_rise) begin n_fail++; $display("FAIL rnd_rise blk=%0d c=%0d got=%b exp=%b", blk, c, bus.rise_o, m_rise); end
                n_checks++;
                if (bus.fall_o !== m_fall) begin n_fail++; $display("FAIL rnd_fall blk=%0d c=%0d got=%b exp=%b", blk, c, bus.fall_o, m_fall); end
                n_checks++;
                if (bus.period_vld_o !== m_vld) begin n_fail++; $display("FAIL rnd_vld blk=%0d c=%0d got=%b exp=%b", blk, c, bus.period_vld_o, m_vld); end
                n_checks++;
                if (bus.period_o !== CNT_W'(m_period)) begin n_fail++; $display("FAIL rnd_period blk=%0d c=%0d got=%0d exp=%0d", blk, c, bus.period_o, m_period); end
                n_checks++;
                if (bus.freq_err_o !== m_err) begin n_fail++; $display("FAIL rnd_err blk=%0d c=%0d got=%b exp=%b", blk, c, bus.freq_err_o, m_err); end
                n_checks++;
                if (bus.clk_lost_o !== m_lost) begin n_fail++; $display("FAIL rnd_lost blk=%0d c=%0d got=%b exp=%b", blk, c, bus.clk_lost_o, m_lost); end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.enable_i = 1'b0;
        test_reset();
        test_nominal();
        test_freq_change();
        test_loss();
        test_latency();
        test_reset_mid();
        test_disable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
